// File: rtl/func_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : func_unit_pkg
// Purpose  : Shared types and constants for the func_unit_pipe datapath:
//            opcode encoding, flag bit positions and MUX lane count.
// Revision : 1.0 - initial release
// ============================================================================
package func_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUX = 2'd1,
    OP_ENC = 2'd2,
    OP_CMP = 2'd3
  } op_e;

  localparam int FLG_HI  = 2;
  localparam int FLG_MID = 1;
  localparam int FLG_LO  = 0;

  localparam int NUM_LANES = 4;

endpackage : func_unit_pkg
`default_nettype wire

// File: rtl/func_unit_core.sv
`default_nettype none
// ============================================================================
// Module   : func_unit_core
// Purpose  : Purely combinational function block. Maps registered
//            op/a/b/cin/sel to a zero-extended WIDTH+1 result and 3 flags.
// Revision : 1.0 - initial release
// ============================================================================
module func_unit_core
  import func_unit_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ENC_IN = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       sel,
  output logic [WIDTH:0]   result,
  output logic [2:0]       flags
);

  localparam int LANE_W = WIDTH / NUM_LANES;
  localparam int IDX_W  = $clog2(ENC_IN);

  logic [WIDTH:0]      add_sum;
  logic [LANE_W-1:0]   lane;
  logic [ENC_IN-1:0]   enc_x;
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_multi;
  logic                cmp_gt;
  logic                cmp_eq;
  logic                cmp_lt;
  logic [WIDTH-1:0]    cmp_diff;

  // Adder keeps the carry-out as the top result bit.
  assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  // Lane select: pick one of the four equal slices of a.
  always_comb begin
    lane = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (sel == 2'(k)) lane = a[k*LANE_W +: LANE_W];
    end
  end

  // Priority encoder: the last (highest) set bit wins; multi-hot is flagged.
  always_comb begin
    enc_x   = a[ENC_IN-1:0];
    enc_idx = '0;
    for (int i = 0; i < ENC_IN; i++) begin
      if (enc_x[i]) enc_idx = IDX_W'(i);
    end
    enc_multi = (enc_x & (enc_x - ENC_IN'(1))) != '0;
  end

  // Unsigned compare with absolute difference, subtracting the smaller side.
  always_comb begin
    cmp_gt   = a > b;
    cmp_eq   = a == b;
    cmp_lt   = a < b;
    cmp_diff = cmp_gt ? (a - b) : (b - a);
  end

  // Output selection by opcode.
  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result          = add_sum;
        flags[FLG_HI]   = add_sum[WIDTH];
        flags[FLG_MID]  = add_sum[WIDTH-1:0] == '0;
      end
      OP_MUX: begin
        result          = {{(WIDTH+1-LANE_W){1'b0}}, lane};
        flags[FLG_MID]  = lane == '0;
      end
      OP_ENC: begin
        result          = {{(WIDTH+1-IDX_W){1'b0}}, enc_idx};
        flags[FLG_HI]   = enc_multi;
        flags[FLG_MID]  = enc_x == '0;
      end
      OP_CMP: begin
        result          = {1'b0, cmp_diff};
        flags[FLG_HI]   = cmp_gt;
        flags[FLG_MID]  = cmp_eq;
        flags[FLG_LO]   = cmp_lt;
      end
      default: begin
        result = '0;
        flags  = '0;
      end
    endcase
  end

endmodule : func_unit_core
`default_nettype wire

// File: rtl/func_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : func_unit_pipe
// Purpose  : Two-stage pipelined multi-function unit (ADD/MUX/ENC/CMP) with
//            valid/ready handshake on both sides and full throughput.
//            Optional per-opcode output-transfer counters are enabled with
//            the macro FUNC_UNIT_OP_COUNT_EN (adds port op_count).
// Revision : 1.0 - initial release
// ============================================================================
module func_unit_pipe
  import func_unit_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ENC_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic [2:0]       flags
`ifdef FUNC_UNIT_OP_COUNT_EN
  ,
  output logic [4*CNT_W-1:0] op_count
`endif
);

  localparam int NUM_OPS = 4;

  // Reject unsupported configurations at elaboration time.
  if ((WIDTH % 4) != 0 || WIDTH < 8 || ENC_IN < 2 || ENC_IN > WIDTH ||
      (ENC_IN & (ENC_IN - 1)) != 0 || CNT_W < 1) begin : g_bad_params
    $error("func_unit_pipe: unsupported parameter combination");
  end

  logic             s1_v;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [1:0]       s1_sel;
  logic             s2_v;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH:0]   core_result;
  logic [2:0]       core_flags;

  // S2 moves when empty or drained; S1 follows S2 (no skid buffer).
  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = s2_adv;
  assign in_ready  = !s1_v || s1_adv;
  assign out_valid = s2_v;

  // Stage 1: capture the operand transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_op  <= OP_ADD;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_cin <= 1'b0;
      s1_sel <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_op  <= op_e'(op);
        s1_a   <= a;
        s1_b   <= b;
        s1_cin <= cin;
        s1_sel <= sel;
      end
    end
  end

  func_unit_core #(
    .WIDTH  (WIDTH),
    .ENC_IN (ENC_IN)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .cin    (s1_cin),
    .sel    (s1_sel),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage 2: register the computed result; hold it while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result <= core_result;
        flags  <= core_flags;
      end
    end
  end

`ifdef FUNC_UNIT_OP_COUNT_EN
  logic [1:0] s2_op;

  // Opcode travelling alongside the S2 result, used only for counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_op <= '0;
    end else if (s2_adv && s1_v) begin
      s2_op <= s1_op;
    end
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op_cnt
    logic [CNT_W-1:0] cnt;

    // Saturating count of output transfers carrying opcode k.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (out_valid && out_ready && s2_op == 2'(k) && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign op_count[k*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule : func_unit_pipe
`default_nettype wire

// File: tb/tb_func_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_func_unit_pipe
// Purpose  : Self-checking bench for func_unit_pipe (WIDTH=16, ENC_IN=4):
//            directed cases, backpressure, random traffic against a
//            behavioural model, and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_func_unit_pipe;
  import func_unit_pkg::*;

  localparam int W  = 16;
  localparam int E  = 4;
  localparam int CW = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [1:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic [2:0]   flags;
`ifdef FUNC_UNIT_OP_COUNT_EN
  logic [4*CW-1:0] op_count;
`endif

  func_unit_pipe #(.WIDTH(W), .ENC_IN(E), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
`ifdef FUNC_UNIT_OP_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [W:0] res;
    logic [2:0] fl;
  } exp_t;

  exp_t q[$];
  int   exp_cnt[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each opcode.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] aa,
                                 input logic [W-1:0] bb, input logic c,
                                 input logic [1:0] s);
    exp_t   r;
    longint x;
    longint t;
    int     hi;
    r.op  = o;
    r.res = '0;
    r.fl  = '0;
    case (o)
      2'd0: begin
        x     = longint'(aa) + longint'(bb) + longint'(c);
        r.res = (W+1)'(x);
        r.fl  = {x >= (longint'(1) << W), (x % (longint'(1) << W)) == 0, 1'b0};
      end
      2'd1: begin
        x     = (longint'(aa) >> (int'(s) * (W/4))) % (longint'(1) << (W/4));
        r.res = (W+1)'(x);
        r.fl  = {1'b0, x == 0, 1'b0};
      end
      2'd2: begin
        x = longint'(aa) % (longint'(1) << E);
        if (x == 0) begin
          r.res = '0;
          r.fl  = 3'b010;
        end else begin
          hi = 0;
          t  = x;
          while (t > 1) begin
            t = t / 2;
            hi++;
          end
          r.res = (W+1)'(hi);
          r.fl  = ($countones(x) > 1) ? 3'b100 : 3'b000;
        end
      end
      default: begin
        if (aa > bb) begin
          r.res = (W+1)'(longint'(aa) - longint'(bb));
          r.fl  = 3'b100;
        end else if (aa == bb) begin
          r.res = '0;
          r.fl  = 3'b010;
        end else begin
          r.res = (W+1)'(longint'(bb) - longint'(aa));
          r.fl  = 3'b001;
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every visible output must match the oldest accepted item.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check("sb_result", 32'(result), 32'(q[0].res));
          check("sb_flags", 32'(flags), 32'(q[0].fl));
          if (out_ready) begin
            if (exp_cnt[q[0].op] < (1 << CW) - 1) exp_cnt[q[0].op]++;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b, cin, sel));
    end
  end

  task automatic send(input string tag, input logic [1:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic c, input logic [1:0] s,
                      input logic [W:0] er, input logic [2:0] ef);
    int guard;
    int lat;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    op        = o;
    a         = aa;
    b         = bb;
    cin       = c;
    sel       = s;
    out_ready = 1'b1;
    guard     = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  task automatic drain(input string tag);
    int guard;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check({tag, "_drained"}, 32'(q.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic check_counts(input string tag);
`ifdef FUNC_UNIT_OP_COUNT_EN
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_cnt%0d", tag, k), 32'(op_count[k*CW +: CW]), 32'(exp_cnt[k]));
    end
`else
    check({tag, "_idle"}, 32'(out_valid), 32'd0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Backpressure: four ADDs with the consumer stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 2'd0;
    a         = 16'd1;
    b         = 16'd1;
    cin       = 1'b0;
    @(negedge clk);
    check("bp_ready1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    a = 16'd2;
    b = 16'd2;
    @(negedge clk);
    check("bp_ready2", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    a = 16'd3;
    b = 16'd3;
    @(negedge clk);
    check("bp_ready_drop", 32'(in_ready), 32'd0);
    check("bp_head_result", 32'(result), 32'd2);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 3; i <= 4; i++) begin
      a     = W'(i);
      b     = W'(i);
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("bp_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    drain("bp");
    check_counts("bp");
`ifdef FUNC_UNIT_OP_COUNT_EN
    check("bp_add_count", 32'(op_count[CW-1:0]), 32'd4);
`endif

    // Directed cases.
    send("add_a", 2'd0, 16'd5, 16'd15, 1'b1, 2'd0, 17'd21, 3'b000);
    send("add_ovf", 2'd0, 16'hFFFF, 16'd1, 1'b0, 2'd0, 17'h10000, 3'b110);
    send("mux_s2", 2'd1, 16'hABCD, 16'd0, 1'b0, 2'd2, 17'd11, 3'b000);
    send("mux_s0", 2'd1, 16'hABCD, 16'd0, 1'b0, 2'd0, 17'd13, 3'b000);
    send("mux_zero", 2'd1, 16'h0F00, 16'd0, 1'b0, 2'd0, 17'd0, 3'b010);
    send("enc_hot", 2'd2, 16'h0008, 16'd0, 1'b0, 2'd0, 17'd3, 3'b000);
    send("enc_multi", 2'd2, 16'h0006, 16'd0, 1'b0, 2'd0, 17'd2, 3'b100);
    send("enc_none", 2'd2, 16'h0000, 16'd0, 1'b0, 2'd0, 17'd0, 3'b010);
    send("cmp_gt", 2'd3, 16'd33, 16'd12, 1'b0, 2'd0, 17'd21, 3'b100);
    send("cmp_lt", 2'd3, 16'd33, 16'd91, 1'b0, 2'd0, 17'd58, 3'b001);
    send("cmp_eq", 2'd3, 16'd7, 16'd7, 1'b0, 2'd0, 17'd0, 3'b010);
    drain("dir");
    check_counts("dir");

    // Random traffic with random consumer stalls.
    repeat (500) begin
      @(posedge clk);
      #1;
      in_valid  = $urandom_range(0, 3) != 0;
      op        = 2'($urandom_range(0, 3));
      a         = W'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      if (op == 2'd2 && $urandom_range(0, 1) == 1)
        a = (a & 16'hFFF0) | W'(1 << $urandom_range(0, 3));
      out_ready = $urandom_range(0, 3) != 0;
    end
    drain("rand");
    check_counts("rand");

    // Reset with two transactions in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 2'd0;
    a         = 16'd10;
    b         = 16'd20;
    cin       = 1'b0;
    @(posedge clk);
    #1 a = 16'd30;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    check("post_rst_result", 32'(result), 32'd0);
    check("post_rst_flags", 32'(flags), 32'd0);
    check_counts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_func_unit_pipe
`default_nettype wire

// File: doc/func_unit_pipe.md
Name: func_unit_pipe

Overview:
- Parametrised, pipelined multi-function datapath unit: ADD, 4-lane MUX, one-hot ENCoder, unsigned CoMParator.
- Selected per transaction by an opcode.
- Valid/ready handshake on input and output, with full throughput and backpressure.
- Sits between an operand source and a result consumer as a shared arithmetic and decode resource.

Parameters:
- WIDTH, 16: operand width. Multiple of 4, >= 8.
- ENC_IN, 4: encoder input width, taken from a[ENC_IN-1:0]. Power of 2, 2..WIDTH.
- CNT_W, 16: per-op counter width. Used only with the optional feature.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: operand transaction valid.
- in_ready  out  1: unit can accept a transaction this cycle.
- op  in  2: 0 ADD, 1 MUX, 2 ENC, 3 CMP.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B.
- cin  in  1: carry-in, ADD only.
- sel  in  2: lane select, MUX only.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- result  out  WIDTH+1: result, zero-extended.
- flags  out  3: op-dependent status, see Behaviour.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, result 0, flags 0. in_ready is 1 in the first cycle after release.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Two stages:
  - S1 registers op/a/b/cin/sel.
  - S2 registers the computed result/flags and drives the outputs.
- Latency: accept in cycle N -> out_valid in cycle N+2 when unstalled. Throughput 1 per cycle.
- Stall rules:
  - S2 advances when !s2_v | out_ready.
  - S1 advances when S2 advances or !s2_v.
  - in_ready = !s1_v | s1_advance (combinational, no skid buffer).
- While out_valid & !out_ready, result and flags hold stable.
- No drop, duplication or reordering.
- ADD:
  - result = a + b + cin, full WIDTH+1 bits.
  - flags = {cout=result[WIDTH], zero=(result[WIDTH-1:0]==0), 0}.
- MUX:
  - a is split into 4 lanes of L = WIDTH/4 bits; lane k = a[k*L +: L].
  - result = lane[sel], zero-extended.
  - flags = {0, zero, 0}.
- ENC:
  - x = a[ENC_IN-1:0].
  - One-hot x: result = index of the set bit, flags = 000.
  - Multi-hot x: result = index of the highest set bit, flags = 100 (err).
  - x == 0: result = 0, flags = 010.
- CMP (unsigned):
  - flags = {a>b, a==b, a<b}. Exactly one bit is set.
  - result = |a-b|, zero-extended.
- Reset asserted mid-operation: all in-flight transactions are discarded immediately. Nothing from them emerges after release.
- out_ready asserted with out_valid low is a don't-care.

Optional Feature:
- Macro: FUNC_UNIT_OP_COUNT_EN.
- Defined:
  - Adds output port op_count, width 4*CNT_W. Slice k counts output transfers with opcode k.
  - Counters are saturating (hold at all-ones) and reset to 0.
  - Increment occurs in the cycle of the output transfer. Visible the next cycle.
- Undefined: port and counters absent. Otherwise identical behaviour.

Decomposition:
- Package func_unit_pkg holds:
  - opcode enum op_e: OP_ADD=0, OP_MUX=1, OP_ENC=2, OP_CMP=3.
  - Flag bit index constants: FLG_HI=2, FLG_MID=1, FLG_LO=0.
  - Lane-count constant NUM_LANES=4.
- Sub-module func_unit_core: purely combinational. Maps registered op/a/b/cin/sel to result/flags.
- func_unit_pipe owns the handshake, stage registers and optional counters.

Test Plan (WIDTH=16, ENC_IN=4):
- ADD a=5, b=15, cin=1 -> result 21, flags 000, out_valid exactly 2 cycles after accept. ADD a=16'hFFFF, b=1, cin=0 -> result 17'h10000, flags 110.
- MUX a=16'hABCD: sel=2 -> result 11, flags 000. sel=0 -> result 13. MUX a=16'h0F00 sel=0 -> result 0, flags 010.
- ENC a=4'b1000 -> result 3, flags 000. a=4'b0110 -> result 2, flags 100. a=0 -> result 0, flags 010.
- CMP 33,12 -> flags 100, result 21. CMP 33,91 -> flags 001, result 58. CMP 7,7 -> flags 010, result 0.
- Backpressure: 4 back-to-back ADDs (i,i,0 for i=1..4) with out_ready low for 5 cycles:
  - in_ready drops after 2 accepts.
  - Outputs are stable while stalled.
  - Results 2,4,6,8 arrive in order.
  - With the feature, op_count[OP_ADD] = 4.
- Reset mid-flight: rst_n low with 2 transactions in flight -> out_valid 0 asynchronously. No output after release. Counters read 0.
